// File: rtl/au_pkg.sv
// Shared definitions for the audio test-tone source: waveform mode encodings,
// default sample width and full-scale helpers.
package au_pkg;

  localparam int AU_DATA_W = 24;

  typedef enum logic [1:0] {
    MODE_SILENT = 2'd0,
    MODE_SINE   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_RAMP   = 2'd3
  } au_mode_e;

  // Largest positive two's-complement value for a data_w-bit sample.
  function automatic logic signed [63:0] fs_max(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value for a data_w-bit sample.
  function automatic logic signed [63:0] fs_min(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/au_sine_rom.sv
// Full-wave sine table with a registered read port (1-cycle latency).
// Contents are computed at elaboration: entry k = round(FS_MAX * sin(2*pi*k/DEPTH)).
module au_sine_rom
  import au_pkg::*;
#(
  parameter int DATA_W = AU_DATA_W,
  parameter int ADDR_W = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ADDR_W-1:0]        addr_i,
  output logic signed [DATA_W-1:0] data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Angle is folded into (-pi, pi] so a fixed-length Taylor series stays accurate
  // to far below one LSB; rounding is half-away-from-zero.
  function automatic logic signed [DATA_W-1:0] sine_entry(input int k);
    real pi_r;
    real x;
    real term;
    real acc;
    real v;
    int  r;
    pi_r = 3.14159265358979323846;
    x    = 2.0 * pi_r * real'(k) / real'(DEPTH);
    if (x > pi_r) x = x - 2.0 * pi_r;
    term = x;
    acc  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    v = real'(fs_max(DATA_W)) * acc;
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return DATA_W'(r);
  endfunction

  logic signed [DATA_W-1:0] rom_tab [DEPTH];
  logic signed [DATA_W-1:0] rom_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    localparam logic signed [DATA_W-1:0] ENTRY = sine_entry(k);
    assign rom_tab[k] = ENTRY;
  end

  // Registered table read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rom_q <= '0;
    else          rom_q <= rom_tab[addr_i];
  end

  assign data_o = rom_q;

endmodule

// File: rtl/au_tone_gen.sv
// Test-tone source: one signed PCM sample per I2S frame, launched on each falling
// edge of ws. Phase accumulator -> sine ROM / square / ramp -> output register.
// Sample latency is fixed at 3 sys_clk cycles after the synchronised tick.
module au_tone_gen
  import au_pkg::*;
#(
  parameter int DATA_W  = AU_DATA_W,
  parameter int ADDR_W  = 7,
  parameter int PHASE_W = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     ws,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [PHASE_W-1:0]       step,
  output logic signed [DATA_W-1:0] au_data,
  output logic                     au_valid
);

  localparam logic signed [DATA_W-1:0] FS_MAX = DATA_W'(fs_max(DATA_W));
  localparam logic signed [DATA_W-1:0] FS_MIN = DATA_W'(fs_min(DATA_W));

  logic                     ws_s1_q, ws_s2_q;
  logic                     tick;

  logic [PHASE_W-1:0]       phase_q, phase_d;

  logic [ADDR_W-1:0]        addr_q;
  logic [PHASE_W-1:0]       ph1_q;
  au_mode_e                 mode1_q;
  logic                     en1_q;
  logic                     vld1_q;

  logic [PHASE_W-1:0]       ph2_q;
  au_mode_e                 mode2_q;
  logic                     en2_q;
  logic                     vld2_q;

  logic signed [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0]        ramp_lj;
  logic signed [DATA_W-1:0] au_data_q, au_data_d;
  logic                     au_valid_q;

  // Two-flop synchroniser for ws; both flops reset low so a ws held low at
  // reset release can never look like a falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ws_s1_q <= 1'b0;
      ws_s2_q <= 1'b0;
    end else begin
      ws_s1_q <= ws;
      ws_s2_q <= ws_s1_q;
    end
  end

  assign tick = ws_s2_q & ~ws_s1_q;

  // Next phase: advance by step while enabled, otherwise park at zero.
  always_comb begin
    phase_d = '0;
    if (enable) phase_d = phase_q + step;
  end

  // Stage 1: capture controls and the pre-increment phase only on tick, so a
  // sample never mixes old and new settings.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      phase_q <= '0;
      addr_q  <= '0;
      ph1_q   <= '0;
      mode1_q <= MODE_SILENT;
      en1_q   <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      vld1_q <= tick;
      if (tick) begin
        addr_q  <= phase_q[PHASE_W-1 -: ADDR_W];
        ph1_q   <= phase_q;
        mode1_q <= au_mode_e'(mode);
        en1_q   <= enable;
        phase_q <= phase_d;
      end
    end
  end

  au_sine_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst),
    .addr_i  (addr_q),
    .data_o  (rom_q)
  );

  // Stage 2: delay phase and flags by one cycle to line up with the ROM output.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ph2_q   <= '0;
      mode2_q <= MODE_SILENT;
      en2_q   <= 1'b0;
      vld2_q  <= 1'b0;
    end else begin
      ph2_q   <= ph1_q;
      mode2_q <= mode1_q;
      en2_q   <= en1_q;
      vld2_q  <= vld1_q;
    end
  end

  // Ramp: phase left-justified into the sample width.
  if (PHASE_W >= DATA_W) begin : g_ramp_trunc
    assign ramp_lj = ph2_q[PHASE_W-1 -: DATA_W];
  end else begin : g_ramp_pad
    assign ramp_lj = {ph2_q, {(DATA_W - PHASE_W){1'b0}}};
  end

  // Waveform select; inverting the ramp MSB maps phase 0 to full-scale negative.
  always_comb begin
    au_data_d = '0;
    if (en2_q) begin
      case (mode2_q)
        MODE_SINE:   au_data_d = rom_q;
        MODE_SQUARE: au_data_d = ph2_q[PHASE_W-1] ? FS_MIN : FS_MAX;
        MODE_RAMP:   au_data_d = $signed({~ramp_lj[DATA_W-1], ramp_lj[DATA_W-2:0]});
        default:     au_data_d = '0;
      endcase
    end
  end

  // Stage 3: registered output and one-cycle valid strobe.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      au_data_q  <= '0;
      au_valid_q <= 1'b0;
    end else begin
      au_valid_q <= vld2_q;
      if (vld2_q) au_data_q <= au_data_d;
    end
  end

  assign au_data  = au_data_q;
  assign au_valid = au_valid_q;

endmodule

// File: tb/tb_au_tone_gen.sv
// Self-checking bench for au_tone_gen (default parameters: 24/7/16).
module tb_au_tone_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        ws      = 1'b1;
  logic        enable  = 1'b0;
  logic [1:0]  mode    = 2'd0;
  logic [15:0] step    = 16'd0;
  logic [23:0] au_data;
  logic        au_valid;

  au_tone_gen dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ws       (ws),
    .enable   (enable),
    .mode     (mode),
    .step     (step),
    .au_data  (au_data),
    .au_valid (au_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Reference model: sine table straight from the defining formula.
  function automatic logic [23:0] rom_ref(input int k);
    real v;
    int  r;
    v = 8388607.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 128.0);
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return r[23:0];
  endfunction

  function automatic logic [23:0] exp_sample(input logic [1:0] m, input logic e,
                                             input logic [15:0] ph);
    if (!e || m == 2'd0) return 24'h000000;
    if (m == 2'd1) return rom_ref(int'(ph) / 512);
    if (m == 2'd2) return (ph >= 16'h8000) ? 24'h800000 : 24'h7FFFFF;
    return {ph, 8'h00} ^ 24'h800000;
  endfunction

  logic [23:0] exp_q[$];
  logic [15:0] phase_m = 16'd0;

  function automatic void push_model(input logic [1:0] m, input logic e, input logic [15:0] s);
    exp_q.push_back(exp_sample(m, e, phase_m));
    phase_m = e ? phase_m + s : 16'd0;
  endfunction

  // Every valid output is checked against the model queue in launch order.
  logic prev_valid = 1'b0;
  always @(negedge sys_clk) begin
    if (au_valid === 1'b1) begin
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid with data %0h, required no valid", au_data);
      end else begin
        check("model_sample", {8'd0, au_data}, {8'd0, exp_q.pop_front()});
      end
    end
    prev_valid = au_valid;
  end

  // Overlapping frame: ws low for lo cycles then high for hi cycles.
  task automatic launch(input logic [1:0] m, input logic e, input logic [15:0] s,
                        input int lo, input int hi);
    @(negedge sys_clk);
    mode = m; enable = e; step = s; ws = 1'b0;
    push_model(m, e, s);
    repeat (lo - 1) @(negedge sys_clk);
    @(negedge sys_clk);
    ws = 1'b1;
    repeat (hi - 1) @(negedge sys_clk);
  endtask

  // Isolated frame: waits for its own sample; lat counts posedges from ws fall.
  task automatic frame(input logic [1:0] m, input logic e, input logic [15:0] s,
                       output logic [23:0] got, output int lat);
    bit seen;
    @(negedge sys_clk);
    mode = m; enable = e; step = s; ws = 1'b0;
    push_model(m, e, s);
    seen = 0;
    lat  = 0;
    got  = 24'hxxxxxx;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      if (au_valid === 1'b1) begin
        seen = 1;
        got  = au_data;
      end
    end
    check("valid_seen", {31'd0, seen}, 32'd1);
    @(negedge sys_clk);
    ws = 1'b1;
    @(negedge sys_clk);
  endtask

  typedef struct {
    logic [1:0]  m;
    logic        e;
    logic [15:0] s;
    bit          chk;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] m, input logic e, input logic [15:0] s,
                              input bit chk, input logic [23:0] exp);
    vec_t v;
    v.m = m; v.e = e; v.s = s; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [23:0] got;
    logic [23:0] ramp_exp [5];
    int          lat;
    int          seen_cnt;
    int          budget;

    ramp_exp = '{24'h800000, 24'hC00000, 24'h000000, 24'h400000, 24'h800000};

    // Sine, 32-sample period.
    for (int i = 0; i <= 32; i++)
      add(2'd1, 1'b1, 16'd2048, (i % 8) == 0,
          (i == 8) ? 24'h7FFFFF : (i == 24) ? 24'h800001 : 24'h000000);
    add(2'd1, 1'b0, 16'd2048, 1, 24'h000000);
    // Square from phase 0.
    for (int i = 0; i < 32; i++)
      add(2'd2, 1'b1, 16'd2048, 1, (i < 16) ? 24'h7FFFFF : 24'h800000);
    // Ramp across a phase wrap.
    for (int i = 0; i < 5; i++) add(2'd3, 1'b1, 16'h4000, 1, ramp_exp[i]);
    add(2'd3, 1'b0, 16'h0000, 1, 24'h000000);
    // Sine to square switch at phase 0x2000, then back to sine at 0x2800.
    for (int i = 0; i < 4; i++) add(2'd1, 1'b1, 16'd2048, i == 0, 24'h000000);
    add(2'd2, 1'b1, 16'd2048, 1, 24'h7FFFFF);
    add(2'd1, 1'b1, 16'd2048, 1, rom_ref(20));
    // Five disabled frames, then re-enable in sine.
    for (int i = 0; i < 5; i++) add(2'((i % 3) + 1), 1'b0, 16'd2048, 1, 24'h000000);
    add(2'd1, 1'b1, 16'd2048, 1, 24'h000000);
    add(2'd1, 1'b1, 16'd2048, 1, rom_ref(4));
    // step = 0 holds the ramp at phase 0x1000.
    add(2'd3, 1'b1, 16'd0, 1, 24'h900000);
    add(2'd3, 1'b1, 16'd0, 1, 24'h900000);

    // Power-on reset.
    repeat (3) @(negedge sys_clk);
    check("reset_valid", {31'd0, au_valid}, 32'd0);
    check("reset_data", {8'd0, au_data}, 32'd0);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Mid-stream reset with samples in flight.
    for (int i = 0; i < 4; i++) launch(2'd1, 1'b1, 16'd2048, 1, 1);
    #3;
    sys_rst = 1'b0;
    exp_q.delete();
    phase_m = 16'd0;
    #1;
    check("async_rst_valid", {31'd0, au_valid}, 32'd0);
    check("async_rst_data", {8'd0, au_data}, 32'd0);
    #96;
    sys_rst = 1'b1;
    seen_cnt = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (au_valid === 1'b1) seen_cnt++;
    end
    check("discard_no_valid", seen_cnt, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      frame(vecs[i].m, vecs[i].e, vecs[i].s, got, lat);
      // ws fall -> tick after one synchroniser edge -> 3 pipeline edges.
      check($sformatf("latency_%0d", i), lat, 4);
      if (vecs[i].chk) check($sformatf("vec_%0d", i), {8'd0, got}, {8'd0, vecs[i].exp});
    end

    // Randomised overlapping frames against the model.
    repeat (300) begin
      logic [15:0] s;
      case ($urandom_range(0, 3))
        0:       s = 16'd0;
        1:       s = 16'($urandom_range(1, 64)) << 9;
        default: s = 16'($urandom);
      endcase
      launch(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, s,
             $urandom_range(1, 3), $urandom_range(1, 3));
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge sys_clk);
      budget++;
    end
    check("drain_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
